// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer and its synchronizer.
//   state_t          : debouncer FSM states
//   SYNC_STAGES_MIN  : lower bound on synchronizer depth
package input_debouncer_pkg;

  typedef enum logic {
    STATE_STABLE  = 1'b0,
    STATE_QUALIFY = 1'b1
  } state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the debouncer and its user.
//   in, enable, filter_len : driven by master (raw line, freeze control, length L)
//   out, busy, glitch      : driven by slave (clean level, qualifying, abort pulse)
interface input_debouncer_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 in;
  logic                 enable;
  logic [CNT_WIDTH-1:0] filter_len;
  logic                 out;
  logic                 busy;
  logic                 glitch;

  modport master (
    output in, enable, filter_len,
    input  out, busy, glitch
  );

  modport slave (
    input  in, enable, filter_len,
    output out, busy, glitch
  );
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, loads RESET_VAL into every stage
//   i_d  : asynchronous input
//   o_q  : synchronized output (last stage)
module sync_chain
  import input_debouncer_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  // Depth below two would defeat metastability protection.
  localparam int unsigned DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {DEPTH{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one asynchronous line: synchronizes it, then only lets a new
// level through to `out` once it has been seen at the synchronizer output
// for filter_len+1 consecutive enabled cycles.
//   clk, reset        : clock and asynchronous active-high reset
//   dbif.in           : raw asynchronous line
//   dbif.enable       : low freezes `out` (and aborts any pending qualification)
//   dbif.filter_len   : qualification length L, compared live each cycle
//   dbif.out          : debounced registered level
//   dbif.busy         : registered, high while a transition is being qualified
//   dbif.glitch       : one-cycle pulse when a candidate transition is aborted
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   dbif
);

  logic                 w_s;
  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_out, w_out_nxt;
  logic                 r_busy;
  logic                 r_glitch, w_glitch_nxt;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .i_d (dbif.in),
    .o_q (w_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= STATE_STABLE;
      r_cnt    <= '0;
      r_out    <= RESET_LEVEL;
      r_busy   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      // Registered from the next state so busy tracks the state register exactly.
      r_busy   <= (w_state_nxt == STATE_QUALIFY);
      r_glitch <= w_glitch_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_glitch_nxt = 1'b0;
    unique case (r_state)
      STATE_STABLE: begin
        if (dbif.enable && (w_s != r_out)) begin
          if (dbif.filter_len == '0) begin
            w_out_nxt = w_s;
          end else begin
            w_state_nxt = STATE_QUALIFY;
            w_cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      STATE_QUALIFY: begin
        if (!dbif.enable) begin
          w_state_nxt = STATE_STABLE;
          w_cnt_nxt   = '0;
        end else if (w_s == r_out) begin
          w_state_nxt  = STATE_STABLE;
          w_cnt_nxt    = '0;
          w_glitch_nxt = 1'b1;
        end else if (r_cnt >= dbif.filter_len) begin
          // >= lets a lowered filter_len complete immediately; counter stays <= L.
          w_out_nxt   = w_s;
          w_state_nxt = STATE_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = STATE_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign dbif.out    = r_out;
  assign dbif.busy   = r_busy;
  assign dbif.glitch = r_glitch;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 8;
  localparam logic        RL   = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  input_debouncer_if #(.CNT_WIDTH(CW)) dbif ();

  input_debouncer #(
    .SYNC_STAGES (SYNC),
    .CNT_WIDTH   (CW),
    .RESET_LEVEL (RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dbif  (dbif)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  bit chk_en    = 1'b0;
  int busy_hi   = 0;
  int glitch_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: a new level must be present at the synchronizer output for L+1
  // consecutive enabled cycles; an interrupted run while enabled is a glitch.
  logic [SYNC-1:0] m_sh;
  logic            m_out, m_busy, m_glitch, m_s;
  int              m_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sh     = {SYNC{RL}};
      m_out    = RL;
      m_busy   = 1'b0;
      m_glitch = 1'b0;
      m_run    = 0;
    end else begin
      cyc++;
      m_glitch = 1'b0;
      m_s      = m_sh[SYNC-1];
      if (dbif.enable && (m_s != m_out)) begin
        m_run++;
        if (m_run >= int'(dbif.filter_len) + 1) begin
          m_out = m_s;
          m_run = 0;
        end
      end else begin
        if (dbif.enable && m_run > 0) m_glitch = 1'b1;
        m_run = 0;
      end
      m_busy = (m_run > 0);
      m_sh   = {m_sh[SYNC-2:0], dbif.in};
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("out",    dbif.out,    m_out);
      check("busy",   dbif.busy,   m_busy);
      check("glitch", dbif.glitch, m_glitch);
      if (dbif.busy)   busy_hi++;
      if (dbif.glitch) glitch_hi++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int t0, busy_edge, out_edge, lag;

  initial begin
    dbif.in         = 1'b0;
    dbif.enable     = 1'b1;
    dbif.filter_len = CW'(4);
    repeat (3) step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle after reset: nothing moves for 50 cycles.
    busy_hi = 0; glitch_hi = 0;
    repeat (50) step();
    check("idle_out", dbif.out, 0);
    check("idle_busy_cycles", busy_hi, 0);
    check("idle_glitch_cycles", glitch_hi, 0);

    // Rising edge, L=4; edges counted with the sampling edge as edge 1.
    glitch_hi = 0;
    dbif.in = 1'b1; t0 = cyc + 1; busy_edge = 0; out_edge = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy_edge == 0 && dbif.busy) busy_edge = cyc - t0 + 1;
      if (out_edge == 0 && dbif.out)   out_edge  = cyc - t0 + 1;
    end
    check("rise_busy_edge", busy_edge, 3);
    check("rise_out_edge", out_edge, 7);
    check("rise_glitch_cycles", glitch_hi, 0);

    // Return low, then a 3-cycle bounce that must be rejected.
    dbif.in = 1'b0;
    repeat (12) step();
    check("fall_out", dbif.out, 0);
    glitch_hi = 0;
    dbif.in = 1'b1;
    repeat (3) step();
    dbif.in = 1'b0;
    repeat (12) step();
    check("bounce_out", dbif.out, 0);
    check("bounce_glitch_cycles", glitch_hi, 1);

    // L=0: out follows with a fixed 3-edge lag, never busy.
    dbif.filter_len = '0;
    busy_hi = 0;
    for (int k = 0; k < 6; k++) begin
      dbif.in = ~dbif.in; t0 = cyc + 1; lag = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (lag == 0 && dbif.out == dbif.in) lag = cyc - t0 + 1;
      end
      check("l0_lag", lag, 3);
    end
    check("l0_busy_cycles", busy_hi, 0);

    // Enable low freezes out; on re-enable out rises on the L+1th edge.
    dbif.filter_len = CW'(4);
    dbif.enable = 1'b0;
    dbif.in = 1'b1;
    repeat (10) step();
    check("frozen_out", dbif.out, 0);
    dbif.enable = 1'b1; t0 = cyc + 1; out_edge = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_edge == 0 && dbif.out) out_edge = cyc - t0 + 1;
    end
    check("reenable_out_edge", out_edge, 5);

    // Enable dropping mid-qualification aborts silently.
    glitch_hi = 0;
    dbif.in = 1'b0;
    repeat (4) step();
    check("abort_pre_busy", dbif.busy, 1);
    dbif.enable = 1'b0;
    step();
    check("abort_busy", dbif.busy, 0);
    check("abort_out", dbif.out, 1);
    check("abort_glitch_cycles", glitch_hi, 0);
    dbif.enable = 1'b1;
    repeat (10) step();
    check("abort_resume_out", dbif.out, 0);

    // Lowering filter_len mid-qualification completes at the next edge.
    dbif.filter_len = CW'(8);
    dbif.in = 1'b1;
    repeat (5) step();
    check("lower_pre_out", dbif.out, 0);
    dbif.filter_len = CW'(2);
    step();
    check("lower_out", dbif.out, 1);

    // Asynchronous reset during qualification (counter = 2).
    dbif.filter_len = CW'(4);
    dbif.in = 1'b0;
    repeat (4) step();
    check("rst_pre_busy", dbif.busy, 1);
    check("rst_pre_out", dbif.out, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", dbif.busy, 0);
    check("rst_out", dbif.out, 0);
    check("rst_glitch", dbif.glitch, 0);
    check("rst_cnt", dut.r_cnt, 0);
    repeat (2) step();
    reset = 1'b0;
    busy_hi = 0; glitch_hi = 0;
    repeat (20) step();
    check("post_rst_out", dbif.out, 0);
    check("post_rst_busy_cycles", busy_hi, 0);
    check("post_rst_glitch_cycles", glitch_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
